stream_chk: RTL and testbench
=============================

STREAM_CHK -- requirements
Module: stream_chk

Interface
REQ-001 Parameter DATA_W, default 8: stream data width in bits.
REQ-002 Parameter BP_PERIOD, default 4 (legal 2..255): backpressure pattern length in cycles.
REQ-003 Parameter TIMEOUT_CYC, default 64: idle-handshake watchdog limit (used only with STREAM_CHK_TIMEOUT_EN).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  one-cycle pulse that begins a check run.
REQ-007 exp_first_i  in  DATA_W  first expected data word, sampled on start_i.
REQ-008 exp_count_i  in  16  number of words to receive, sampled on start_i.
REQ-009 bp_en_i  in  1  enables the periodic ready-deassertion pattern.
REQ-010 u2d_data_i  in  DATA_W  stream data from the upstream node.
REQ-011 u2d_valid_i  in  1  upstream valid.
REQ-012 u2d_ready_o  out  1  ready to upstream.
REQ-013 busy_o  out  1  high while a run is in progress.
REQ-014 done_o  out  1  one-cycle pulse when a run ends.
REQ-015 pass_o  out  1  equals (err_cnt_o==0), qualified by done_o.
REQ-016 rx_cnt_o  out  16  words accepted in the current or last run.
REQ-017 err_cnt_o  out  16  mismatching words, saturating at 16'hFFFF.
REQ-018 first_err_o  out  DATA_W  data value of the first mismatching word.
REQ-019 timeout_o  out  1  set when a run ended by watchdog (STREAM_CHK_TIMEOUT_EN only).

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 IDLE: u2d_ready_o=0; start_i loads exp=exp_first_i and remaining=exp_count_i, and clears rx_cnt_o, err_cnt_o, first_err_o, timeout_o and the bp counter; next state is RUN, or DONE if exp_count_i==0.
REQ-022 RUN: u2d_ready_o = !(bp_en_i && bp_cnt==BP_PERIOD-1); ready SHALL NOT depend combinationally on u2d_valid_i or u2d_data_i.
REQ-023 bp_cnt SHALL be free-running modulo BP_PERIOD in RUN, starting at 0 in the first RUN cycle.
REQ-024 A handshake is u2d_valid_i & u2d_ready_o at a rising edge; only handshakes change rx_cnt_o, exp or the error state.
REQ-025 On each handshake: rx_cnt_o+1; if data!=exp then err_cnt_o+1 (saturating), and first_err_o captures the data when err_cnt_o was 0; exp <= exp+1 modulo 2^DATA_W, independent of mismatch.
REQ-026 The handshake that makes rx_cnt_o equal to the sampled count SHALL move RUN->DONE; no further words are accepted.
REQ-027 DONE lasts exactly one cycle with done_o=1 and u2d_ready_o=0, then returns to IDLE.
REQ-028 busy_o=1 in RUN and DONE, 0 in IDLE.
REQ-029 start_i in RUN or DONE SHALL be ignored.
REQ-030 Result outputs hold their values in IDLE until the next accepted start_i.

Reset
REQ-031 rst SHALL force IDLE and clear all counters, exp, first_err_o and timeout_o; all outputs read 0 in the cycle after rst is sampled high.
REQ-032 rst asserted mid-run SHALL abort the run without a done_o pulse; any handshake in that cycle is not counted.

Configuration
REQ-033 With STREAM_CHK_TIMEOUT_EN defined: a watchdog counts RUN cycles without a handshake, is cleared by each handshake, and at TIMEOUT_CYC sets timeout_o=1 and forces RUN->DONE; pass_o is then 0.
REQ-034 Without STREAM_CHK_TIMEOUT_EN: no watchdog logic exists, timeout_o is tied 0, and a run waits indefinitely.

Verification
REQ-035 exp_first=0, count=16, bp off, valid held high with data 0..15 -> 16 consecutive handshakes, done_o 16 cycles after RUN entry, rx=16, err=0, pass=1.
REQ-036 exp_first=0, count=5, data 0,1,2,5,4 -> err=1, first_err=5, pass=0, rx=5.
REQ-037 exp_first=254, count=4, data 254,255,0,1 -> err=0 (wrap-around accepted).
REQ-038 bp_en=1, BP_PERIOD=4, valid held high -> ready pattern 1,1,1,0 repeating; count=8 completes in 10 cycles.
REQ-039 rst for one cycle after 3 of 8 words -> IDLE, all outputs 0, no done_o; a fresh start then runs normally.
REQ-040 count=0 -> done_o one cycle after start, rx=0, pass=1; with STREAM_CHK_TIMEOUT_EN and valid held low for 64 cycles -> timeout_o=1, done_o, pass=0.

Source files
------------

// File: rtl/stream_chk_if.sv
// stream_chk_if -- upstream-to-downstream valid/ready stream bundle.
//   u2d_data  : stream data word, DATA_W bits (driven by the upstream node)
//   u2d_valid : upstream has a word on u2d_data
//   u2d_ready : downstream accepts the word at this rising edge
// Modports: master = upstream node, slave = the checker.
interface stream_chk_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] u2d_data;
  logic              u2d_valid;
  logic              u2d_ready;

  modport master (output u2d_data, output u2d_valid, input  u2d_ready);
  modport slave  (input  u2d_data, input  u2d_valid, output u2d_ready);
endinterface

// File: rtl/stream_chk.sv
// stream_chk -- stream receive checker.
// After a start pulse it accepts exp_count_i words from the upstream stream
// and compares each one against an incrementing expected value that begins
// at exp_first_i and wraps modulo 2^DATA_W. It reports the number of words
// received, the number of mismatches and the first mismatching word.
// An optional periodic ready-deassertion pattern exercises upstream
// backpressure handling.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         one-cycle pulse, begins a run (ignored unless idle)
//   exp_first_i     first expected word, sampled on start_i
//   exp_count_i     words to receive, sampled on start_i
//   bp_en_i         enables ready deassertion every BP_PERIOD-th run cycle
//   u2d             stream_chk_if.slave (data/valid in, ready out)
//   busy_o          run in progress (RUN or DONE)
//   done_o          one-cycle pulse at run end
//   pass_o          no mismatches and no timeout, valid only with done_o
//   rx_cnt_o        words accepted in the current/last run
//   err_cnt_o       mismatching words, saturating
//   first_err_o     data of the first mismatching word
//   timeout_o       run ended by the watchdog
//
// Build option: define STREAM_CHK_TIMEOUT_EN to add a watchdog that ends a
// run after TIMEOUT_CYC consecutive run cycles without a handshake.
// Without it timeout_o is tied low and a run waits indefinitely.
module stream_chk #(
  parameter int DATA_W      = 8,
  parameter int BP_PERIOD   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] exp_first_i,
  input  logic [15:0]       exp_count_i,
  input  logic              bp_en_i,
  stream_chk_if.slave       u2d,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       rx_cnt_o,
  output logic [15:0]       err_cnt_o,
  output logic [DATA_W-1:0] first_err_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0]        BP_LAST = 8'(BP_PERIOD - 1);
  localparam logic [DATA_W-1:0] ONE_W   = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [7:0]        r_bp_cnt;
  logic [DATA_W-1:0] r_exp;
  logic [15:0]       r_count;
  logic [15:0]       r_rx_cnt;
  logic [15:0]       r_err_cnt;
  logic [DATA_W-1:0] r_first_err;
  logic              r_timeout;

  logic              w_ready;
  logic              w_hs;

  // Ready depends only on state, the pattern counter and bp_en_i, never on
  // the upstream valid/data, so no combinational loop through a
  // ready-after-valid upstream is possible.
  assign w_ready = (r_state == S_RUN) && !(bp_en_i && (r_bp_cnt == BP_LAST));
  assign w_hs    = w_ready && u2d.u2d_valid;

`ifdef STREAM_CHK_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bp_cnt    <= '0;
      r_exp       <= '0;
      r_count     <= '0;
      r_rx_cnt    <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_timeout   <= 1'b0;
`ifdef STREAM_CHK_TIMEOUT_EN
      r_wd        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_exp       <= exp_first_i;
            r_count     <= exp_count_i;
            r_rx_cnt    <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
            r_bp_cnt    <= '0;
`ifdef STREAM_CHK_TIMEOUT_EN
            r_wd        <= '0;
`endif
            r_state     <= (exp_count_i == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_bp_cnt <= (r_bp_cnt == BP_LAST) ? 8'd0 : r_bp_cnt + 8'd1;
          if (w_hs) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
            if (u2d.u2d_data != r_exp) begin
              if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
              if (r_err_cnt == 16'd0)    r_first_err <= u2d.u2d_data;
            end
            // expected value advances on every accepted word, match or not
            r_exp <= r_exp + ONE_W;
            if (r_rx_cnt + 16'd1 == r_count) r_state <= S_DONE;
          end
`ifdef STREAM_CHK_TIMEOUT_EN
          if (w_hs) begin
            r_wd <= '0;
          end else if (r_wd == WD_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign u2d.u2d_ready = w_ready;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign pass_o        = done_o && (r_err_cnt == 16'd0) && !r_timeout;
  assign rx_cnt_o      = r_rx_cnt;
  assign err_cnt_o     = r_err_cnt;
  assign first_err_o   = r_first_err;
`ifdef STREAM_CHK_TIMEOUT_EN
  assign timeout_o     = r_timeout;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_stream_chk.sv
// tb_stream_chk -- self-checking bench for stream_chk (DATA_W=8,
// BP_PERIOD=4, TIMEOUT_CYC=64). Inputs are driven and outputs sampled on the
// falling edge. The reference model tracks a run as plain arithmetic: the
// k-th accepted word should equal (first + k) mod 256, ready is low on every
// run cycle whose index mod 4 equals 3 when backpressure is on.
module tb_stream_chk;
  localparam int DW  = 8;
  localparam int BP  = 4;
  localparam int TO  = 64;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [DW-1:0] exp_first_i;
  logic [15:0]   exp_count_i;
  logic          bp_en_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [15:0]   rx_cnt_o, err_cnt_o;
  logic [DW-1:0] first_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] dq[$];   // explicit word sequence, empty = random words

  stream_chk_if #(.DATA_W(DW)) u2d ();

  stream_chk #(.DATA_W(DW), .BP_PERIOD(BP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .exp_first_i(exp_first_i),
    .exp_count_i(exp_count_i), .bp_en_i(bp_en_i), .u2d(u2d),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .rx_cnt_o(rx_cnt_o),
    .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(u2d.u2d_ready), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
    chk({tag, "_done"},  32'(done_o), 0);
    chk({tag, "_pass"},  32'(pass_o), 0);
    chk({tag, "_rx"},    32'(rx_cnt_o), 0);
    chk({tag, "_err"},   32'(err_cnt_o), 0);
    chk({tag, "_ferr"},  32'(first_err_o), 0);
    chk({tag, "_tmo"},   32'(timeout_o), 0);
  endtask

  // One complete run. vpct: valid probability (%), epct: corrupted word
  // probability (%), exp_cyc: required run cycles before DONE (-1 = any).
  task automatic run(input string tag, input logic [DW-1:0] first, input int count,
                     input bit bp, input int vpct, input int epct, input int exp_cyc);
    int acc, errs, cyc;
    logic [DW-1:0] ferr, w, expw;
    bit v, rdy_m;
    @(negedge clk);
    start_i = 1'b1; exp_first_i = first; exp_count_i = 16'(count); bp_en_i = bp;
    @(negedge clk);
    acc = 0; errs = 0; ferr = '0; cyc = 0;
    while (acc < count && cyc < BUDGET) begin
      rdy_m = !(bp && (cyc % BP) == BP - 1);
      chk({tag, "_ready"}, 32'(u2d.u2d_ready), 32'(rdy_m));
      v    = ($urandom_range(99) < vpct);
      expw = DW'(first + acc);
      if (dq.size() > 0) w = dq[0];
      else w = ($urandom_range(99) < epct) ? (expw ^ DW'($urandom_range(1, 255))) : expw;
      u2d.u2d_valid = v; u2d.u2d_data = w;
      // stray starts while busy must be ignored
      start_i = ($urandom_range(3) == 0);
      exp_first_i = DW'($urandom); exp_count_i = 16'($urandom_range(1, 3));
      @(negedge clk);
      if (v && rdy_m) begin
        if (w !== expw) begin
          if (errs == 0) ferr = w;
          errs++;
        end
        acc++;
        if (dq.size() > 0) void'(dq.pop_front());
      end
      cyc++;
    end
    chk({tag, "_in_budget"}, 32'(acc), 32'(count));
    // DONE cycle
    start_i = ($urandom_range(1) == 0);
    u2d.u2d_valid = 1'b1;
    chk({tag, "_done"},  32'(done_o), 1);
    chk({tag, "_busy"},  32'(busy_o), 1);
    chk({tag, "_rdy0"},  32'(u2d.u2d_ready), 0);
    chk({tag, "_rx"},    32'(rx_cnt_o), 32'(count));
    chk({tag, "_err"},   32'(err_cnt_o), 32'(errs));
    chk({tag, "_ferr"},  32'(first_err_o), 32'(ferr));
    chk({tag, "_pass"},  32'(pass_o), 32'(errs == 0));
    chk({tag, "_tmo"},   32'(timeout_o), 0);
    if (exp_cyc >= 0) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    start_i = 1'b0; u2d.u2d_valid = 1'b0;
    // back in IDLE, results held
    chk({tag, "_idle_busy"}, 32'(busy_o), 0);
    chk({tag, "_idle_done"}, 32'(done_o), 0);
    chk({tag, "_idle_rdy"},  32'(u2d.u2d_ready), 0);
    chk({tag, "_hold_rx"},   32'(rx_cnt_o), 32'(count));
    chk({tag, "_hold_err"},  32'(err_cnt_o), 32'(errs));
    chk({tag, "_hold_ferr"}, 32'(first_err_o), 32'(ferr));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; exp_first_i = '0; exp_count_i = '0; bp_en_i = 1'b0;
    u2d.u2d_valid = 1'b0; u2d.u2d_data = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // 16 back-to-back words, done 16 cycles after RUN entry
    run("seq16", 8'd0, 16, 1'b0, 100, 0, 16);

    // single corrupted word in position 3
    dq = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd4};
    run("err1", 8'd0, 5, 1'b0, 100, 0, 5);

    // expected value wraps past 255
    dq = '{8'd254, 8'd255, 8'd0, 8'd1};
    run("wrap", 8'd254, 4, 1'b0, 100, 0, 4);

    // backpressure 1,1,1,0: 8 words need 10 cycles
    run("bp8", 8'd7, 8, 1'b1, 100, 0, 10);

    // zero-length run: DONE straight after start
    run("cnt0", 8'd9, 0, 1'b0, 100, 0, 0);

    // reset after 3 of 8 words aborts without done
    @(negedge clk);
    start_i = 1'b1; exp_first_i = 8'h10; exp_count_i = 16'd8; bp_en_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      u2d.u2d_valid = 1'b1; u2d.u2d_data = 8'(8'h10 + k);
      @(negedge clk);
    end
    chk("abort_rx_pre", 32'(rx_cnt_o), 3);
    u2d.u2d_data = 8'h55; rst = 1'b1;   // mismatching word offered during reset
    @(negedge clk);
    rst = 1'b0; u2d.u2d_valid = 1'b0;
    chk_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_o), 0);
    end
    run("after_abort", 8'h20, 6, 1'b0, 100, 0, 6);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      run("rand", DW'($urandom), $urandom_range(1, 40), 1'($urandom_range(1)), 60, 25, -1);
    end

`ifdef STREAM_CHK_TIMEOUT_EN
    begin
      int cyc;
      @(negedge clk);
      start_i = 1'b1; exp_first_i = 8'd0; exp_count_i = 16'd5; bp_en_i = 1'b0;
      u2d.u2d_valid = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (!done_o && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("tmo_cycles", 32'(cyc), 64);
      chk("tmo_done",   32'(done_o), 1);
      chk("tmo_flag",   32'(timeout_o), 1);
      chk("tmo_pass",   32'(pass_o), 0);
      chk("tmo_rx",     32'(rx_cnt_o), 0);
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
